sample_player: RTL and testbench
================================

SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 Parameter SAMPLE_W, 19, width of one sample in bits, two's complement.
REQ-002 Parameter CHANNELS, 1, 1 = mono ROM word; 2 = stereo ROM word (left in upper SAMPLE_W bits).
REQ-003 Parameter ADDR_W, 23, ROM address width.
REQ-004 Parameter LAST_ADDR, 50160, final ROM address of the clip.
REQ-005 Parameter RATE_DIV, 10000, clock cycles per sample fetch, minimum 4.
REQ-006 Parameter FIFO_DEPTH, 4, sample FIFO entries, power of two, minimum 2.
REQ-007 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-008 resetn  in  1  reset, asynchronous assert, active-low.
REQ-009 start  in  1  one-cycle pulse; begin or restart playback at address 0.
REQ-010 stop  in  1  one-cycle pulse; abort playback.
REQ-011 loop_en  in  1  level; 1 = wrap from LAST_ADDR to 0 instead of ending.
REQ-012 vol_shift  in  5  left shift applied to each output sample, 0..31.
REQ-013 rom_addr  out  ADDR_W  registered address to the synchronous ROM.
REQ-014 rom_q  in  CHANNELS*SAMPLE_W  ROM data, valid one cycle after rom_addr is updated.
REQ-015 audio_out_allowed  in  1  the audio controller can accept one sample pair.
REQ-016 left_channel_audio_out / right_channel_audio_out  out  32 each  registered sample pair.
REQ-017 write_audio_out  out  1  one-cycle pulse; sample pair is valid.
REQ-018 busy  out  1  high in PLAY or DRAIN.
REQ-019 done  out  1  one-cycle pulse on natural end of a non-looping clip.
REQ-020 overflow  out  1  sticky; a fetched sample was dropped because the FIFO was full.

Function
REQ-021 The FSM shall have three states, IDLE, PLAY and DRAIN, and shall hold IDLE after reset.
REQ-022 A start pulse in any state shall flush the FIFO, clear overflow, set rom_addr=0, clear the rate counter and enter PLAY.
REQ-023 A stop pulse in PLAY or DRAIN shall flush the FIFO and enter IDLE without a done pulse; if start and stop arrive in the same cycle, stop shall win.
REQ-024 In PLAY, the rate counter shall count 0..RATE_DIV-1 and wrap; each wrap is a fetch tick.
REQ-025 On the cycle after a tick, the block shall push rom_q into the FIFO; if the FIFO is full, it shall drop the sample and set overflow.
REQ-026 On that same push cycle, rom_addr shall advance by 1 if it is below LAST_ADDR; at LAST_ADDR it shall go to 0 if loop_en=1, otherwise the FSM shall enter DRAIN with rom_addr held.
REQ-027 The first fetch shall occur RATE_DIV cycles after the start pulse, and the first push one cycle later.
REQ-028 In DRAIN, when the FIFO is empty and no write is pending, the block shall pulse done for one cycle and enter IDLE.
REQ-029 The FIFO shall pop when it is not empty, audio_out_allowed=1 and write_audio_out was 0 in the previous cycle, so writes are at least 2 cycles apart.
REQ-030 On a pop, write_audio_out shall be 1 in the next cycle, with the output registers loaded in the same edge.
REQ-031 Each output sample shall be the SAMPLE_W value sign-extended to 32 bits, shifted left by vol_shift and truncated to 32 bits.
REQ-032 If CHANNELS=1, both outputs shall carry the same sample; if CHANNELS=2, left shall take the upper half and right the lower half.
REQ-033 A push and a pop in the same cycle shall leave the FIFO occupancy unchanged, and a full FIFO that pops shall accept the simultaneous push.
REQ-034 Output registers shall hold their value between writes.
REQ-035 busy shall be a registered decode of the state.

Reset
REQ-036 resetn=0 shall asynchronously force: state IDLE, rom_addr 0, rate counter 0, FIFO empty, both audio outputs 0, write_audio_out 0, busy 0, done 0, overflow 0.
REQ-037 Reset asserted mid-playback shall take effect immediately with no pending write emitted; deassertion shall be synchronous to CLOCK_50.

Verification (SAMPLE_W=8, CHANNELS=1, LAST_ADDR=3, RATE_DIV=4, FIFO_DEPTH=2, ROM[i]=i+1, allowed=1)
REQ-038 start, loop_en=0, vol_shift=0 -> rom_addr 0,1,2,3; writes carry 1,2,3,4; then one done pulse; busy falls in the same cycle as done.
REQ-039 loop_en=1, run 10 ticks -> output sequence 1,2,3,4,1,2,3,4,1,2; done never pulses.
REQ-040 ROM[0]=8'h80, vol_shift=4 -> first write is 32'hFFFFF800 on both channels.
REQ-041 allowed held at 0 for 4 ticks -> overflow=1 after the third push; releasing allowed yields 1,2 in that order; the next start clears overflow.
REQ-042 stop one cycle after the second push -> no further writes, FIFO empty, done=0, state IDLE; start and stop in the same cycle -> stays IDLE.
REQ-043 resetn pulsed low mid-PLAY -> all outputs are 0 within the same cycle, with no write_audio_out pulse after release.

Source files
------------

// File: rtl/sample_player.sv
// Sample player: paces reads from a synchronous ROM at a fixed clip rate,
// buffers the samples in a small FIFO and hands sample pairs to an audio
// controller whenever it signals it can take one.
//
// state | meaning
// IDLE  | no clip active, FIFO empty
// PLAY  | fetching one ROM word every RATE_DIV cycles
// DRAIN | clip fetched completely, emptying the FIFO before done
module sample_player #(
  parameter int SAMPLE_W   = 19,
  parameter int CHANNELS   = 1,
  parameter int ADDR_W     = 23,
  parameter int LAST_ADDR  = 50160,
  parameter int RATE_DIV   = 10000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [4:0]                   vol_shift,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [CHANNELS*SAMPLE_W-1:0] rom_q,
  input  logic                         audio_out_allowed,
  output logic [31:0]                  left_channel_audio_out,
  output logic [31:0]                  right_channel_audio_out,
  output logic                         write_audio_out,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int WORD_W = CHANNELS * SAMPLE_W;
  localparam int CNT_W  = $clog2(RATE_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   rate_cnt;
  logic               tick_q;
  logic [WORD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     fifo_cnt;
  logic               fifo_empty, fifo_full;
  logic               restart, flush, push, pop, accept, at_last, done_nxt;
  logic [WORD_W-1:0]  head;
  logic [31:0]        left_nxt, right_nxt;

  // Sign-extend one sample to 32 bits, then apply the volume shift.
  function automatic logic [31:0] scale(input logic [SAMPLE_W-1:0] s,
                                        input logic [4:0] sh);
    logic signed [SAMPLE_W-1:0] ss;
    logic signed [31:0]         ext;
    ss  = s;
    ext = 32'(ss);
    return ext << sh;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  generate
    if (CHANNELS == 2) begin : g_stereo
      assign left_nxt  = scale(head[WORD_W-1 -: SAMPLE_W], vol_shift);
      assign right_nxt = scale(head[SAMPLE_W-1:0], vol_shift);
    end else begin : g_mono
      assign left_nxt  = scale(head[SAMPLE_W-1:0], vol_shift);
      assign right_nxt = left_nxt;
    end
  endgenerate

  // Next-state decode plus the per-cycle push/pop/flush strobes.
  // stop beats start; a push is the cycle after a rate tick, when rom_q
  // reflects the current rom_addr. Pops are spaced so writes are >= 2 apart.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    restart   = start && !stop;
    flush     = restart || (stop && state != S_IDLE);
    push      = (state == S_PLAY) && tick_q && !start && !stop;
    pop       = !fifo_empty && audio_out_allowed && !write_audio_out && !start && !stop;
    accept    = push && (!fifo_full || pop);
    at_last   = (rom_addr == ADDR_W'(LAST_ADDR));
    if (stop && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else if (restart) begin
      state_nxt = S_PLAY;
    end else begin
      case (state)
        S_PLAY:  if (push && at_last && !loop_en) state_nxt = S_DRAIN;
        S_DRAIN: if (fifo_empty && !write_audio_out) begin
                   state_nxt = S_IDLE;
                   done_nxt  = 1'b1;
                 end
        default: ;
      endcase
    end
  end

  // State register with registered busy/done decode.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= done_nxt;
    end
  end

  // Rate counter: runs 0..RATE_DIV-1 only in PLAY, tick_q flags each wrap.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rate_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (flush || state != S_PLAY) begin
      rate_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q   <= (rate_cnt == CNT_W'(RATE_DIV - 1));
      rate_cnt <= (rate_cnt == CNT_W'(RATE_DIV - 1)) ? '0 : rate_cnt + CNT_W'(1);
    end
  end

  // ROM address: advances on every push, dropped samples included.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rom_addr <= '0;
    end else if (restart) begin
      rom_addr <= '0;
    end else if (push) begin
      if (!at_last)     rom_addr <= rom_addr + ADDR_W'(1);
      else if (loop_en) rom_addr <= '0;
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge CLOCK_50) begin
    if (accept) fifo_mem[wr_ptr] <= rom_q;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      if (restart) overflow <= 1'b0;
    end else begin
      if (accept)        wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)           rd_ptr   <= rd_ptr + PTR_W'(1);
      if (push && !accept) overflow <= 1'b1;
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
    end
  end

  // Output registers load on a pop and hold otherwise.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      write_audio_out <= pop;
      if (pop) begin
        left_channel_audio_out  <= left_nxt;
        right_channel_audio_out <= right_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sample_player.sv
// Bench for sample_player: a queue-based clip model checked every cycle,
// plus directed scenarios with hand-computed sample sequences.
module tb_sample_player;

  localparam int SW    = 8;
  localparam int AW    = 8;
  localparam int LAST  = 3;
  localparam int RD    = 4;
  localparam int DEPTH = 2;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, allowed = 1'b1;
  logic [4:0]    vol_shift = 5'd0;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] rom_q;
  logic [31:0]   left, right;
  logic          wr, busy, done, overflow;
  logic [SW-1:0] rom [0:255];

  int n_vec = 0, n_bad = 0, n_done = 0;
  int cap[$];
  int exp_q[$];

  sample_player #(
    .SAMPLE_W(SW), .CHANNELS(1), .ADDR_W(AW), .LAST_ADDR(LAST),
    .RATE_DIV(RD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .vol_shift(vol_shift), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(allowed), .left_channel_audio_out(left),
    .right_channel_audio_out(right), .write_audio_out(wr), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous ROM.
  always @(posedge CLOCK_50) rom_q <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_st, m_k, m_addr;   // m_st: 0 stopped, 1 fetching, 2 finishing
  int          q[$];
  bit          m_wr, m_busy, m_done, m_ovf;
  logic [31:0] m_out;
  bit          md_stop, md_start, md_pop, md_fin;

  function automatic logic [31:0] conv(input logic [7:0] s, input logic [4:0] sh);
    logic [31:0] e;
    e = {{24{s[7]}}, s};
    return e << sh;
  endfunction

  // Model: k counts edges since start; a ROM word enters the queue at k = RD*n + 1.
  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      m_st = 0; m_k = 0; m_addr = 0; q.delete();
      m_wr = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_out = 0;
    end else begin
      md_stop  = stop && m_st != 0;
      md_start = start && !stop;
      md_pop   = q.size() > 0 && allowed && !m_wr && !start && !stop;
      md_fin   = m_st == 2 && q.size() == 0 && !m_wr && !start && !stop;
      m_done   = 0;
      if (md_pop) m_out = conv(8'(q.pop_front()), vol_shift);
      m_wr = md_pop;
      if (md_stop) begin
        q.delete(); m_st = 0; m_k = 0;
      end else if (md_start) begin
        q.delete(); m_st = 1; m_k = 0; m_addr = 0; m_ovf = 0;
      end else if (m_st == 1) begin
        m_k++;
        if (m_k > 1 && (m_k - 1) % RD == 0) begin
          if (q.size() < DEPTH) q.push_back(int'(rom[m_addr]));
          else m_ovf = 1;
          if (m_addr < LAST) m_addr++;
          else if (loop_en) m_addr = 0;
          else m_st = 2;
        end
      end else if (md_fin) begin
        m_st = 0; m_done = 1;
      end
      m_busy = (m_st != 0);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge CLOCK_50) begin
    check("write_audio_out", {31'd0, wr}, {31'd0, m_wr});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("left", left, m_out);
    check("right", right, m_out);
  end

  // Record written samples and done pulses for the directed checks.
  always @(negedge CLOCK_50) begin
    if (wr) cap.push_back(int'(left));
    if (done) n_done++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic wait_cap(input string name, input int n, input int budget);
    int c = 0;
    while (cap.size() < n && c < budget) begin step(); c++; end
    check({name, " write count reached"}, 32'(cap.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!done && c < budget) begin step(); c++; end
    check({name, " done seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_cap(input string name);
    check({name, " length"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check(name, 32'(cap[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 1);
    resetn = 1'b0;
    repeat (3) step();
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset write", {31'd0, wr}, 32'd0);
    check("reset left", left, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;
    repeat (2) step();

    // one-shot clip
    cap.delete(); n_done = 0; loop_en = 1'b0;
    pulse_start();
    wait_done("oneshot", 60);
    check("oneshot busy at done", {31'd0, busy}, 32'd0);
    check("oneshot addr held", 32'(rom_addr), 32'd3);
    step();
    exp_q = '{1, 2, 3, 4};
    check_cap("oneshot samples");
    repeat (5) step();
    check("oneshot done count", 32'(n_done), 32'd1);

    // looping clip, 10 fetches
    loop_en = 1'b1; cap.delete(); n_done = 0;
    pulse_start();
    wait_cap("loop", 10, 80);
    pulse_stop();
    repeat (3) step();
    exp_q = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
    check_cap("loop samples");
    check("loop done count", 32'(n_done), 32'd0);
    loop_en = 1'b0;

    // negative sample with volume shift
    rom[0] = 8'h80; vol_shift = 5'd4; cap.delete();
    pulse_start();
    wait_cap("volume", 1, 20);
    check("volume left", left, 32'hFFFFF800);
    check("volume right", right, 32'hFFFFF800);
    pulse_stop();
    rom[0] = 8'd1; vol_shift = 5'd0;
    step();

    // back-pressure overflow
    allowed = 1'b0; cap.delete();
    pulse_start();
    repeat (12) step();
    check("overflow before third push", {31'd0, overflow}, 32'd0);
    step();
    check("overflow after third push", {31'd0, overflow}, 32'd1);
    repeat (4) step();
    allowed = 1'b1;
    wait_done("overflow drain", 30);
    step();
    exp_q = '{1, 2};
    check_cap("overflow samples");
    check("overflow sticky", {31'd0, overflow}, 32'd1);
    pulse_start();
    check("overflow cleared by start", {31'd0, overflow}, 32'd0);
    pulse_stop();
    step();

    // stop one cycle after the second push
    cap.delete(); n_done = 0;
    pulse_start();
    repeat (9) step();
    pulse_stop();
    repeat (20) step();
    exp_q = '{1};
    check_cap("stop samples");
    check("stop busy", {31'd0, busy}, 32'd0);
    check("stop done count", 32'(n_done), 32'd0);

    // start and stop together, from IDLE and from PLAY
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (8) step();
    check("start+stop idle busy", {31'd0, busy}, 32'd0);
    pulse_start();
    repeat (3) step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("start+stop play busy", {31'd0, busy}, 32'd0);
    repeat (8) step();

    // asynchronous reset mid-play with a write about to be issued
    cap.delete();
    pulse_start();
    repeat (9) step();
    #3 resetn = 1'b0;
    #1;
    check("async rst write", {31'd0, wr}, 32'd0);
    check("async rst left", left, 32'd0);
    check("async rst right", right, 32'd0);
    check("async rst addr", 32'(rom_addr), 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    cap.delete();
    repeat (20) step();
    check("no write after reset", 32'(cap.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
